// File: rtl/systolic_feeder.sv
// systolic_feeder: stages A (N x KMAX) and B (KMAX x N) operand banks and streams
// them into the row/column edges of an N x N systolic array with the diagonal
// skew, then flushes with zeros so the last operands reach PE(N-1,N-1).
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   wr_en_i..wr_data_i bank write port, accepted only while idle
//   start_i, k_len_i   run request and inner length (saturated to KMAX)
//   a_edge_o, b_edge_o N slices of DW bits feeding array rows / columns
//   pe_en_o            PE enable broadcast, high for Keff+2N-2 cycles
//   busy_o, done_o     run in progress / one-cycle end-of-run pulse
//   cyc_cnt_o          16-bit PE_EN cycle counter, present only when the macro
//                      SYSTOLIC_FEEDER_CYCCNT_EN is defined
module systolic_feeder #(
    parameter int unsigned N    = 4,
    parameter int unsigned KMAX = 8,
    parameter int unsigned DW   = 32,
    localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned KW  = (KMAX > 1) ? $clog2(KMAX) : 1,
    localparam int unsigned KLW = $clog2(KMAX) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            wr_en_i,
    input  logic            wr_sel_i,
    input  logic [IW-1:0]   wr_idx_i,
    input  logic [KW-1:0]   wr_k_i,
    input  logic [DW-1:0]   wr_data_i,
    input  logic            start_i,
    input  logic [KLW-1:0]  k_len_i,
    output logic [N*DW-1:0] a_edge_o,
    output logic [N*DW-1:0] b_edge_o,
    output logic            pe_en_o,
    output logic            busy_o,
`ifdef SYSTOLIC_FEEDER_CYCCNT_EN
    output logic [15:0]     cyc_cnt_o,
`endif
    output logic            done_o
);

    // Counter must hold Keff+2N-3 at its largest.
    localparam int unsigned TW = $clog2(KMAX + 2 * N);

    typedef enum logic [1:0] {StIdle, StFeed, StFin} state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     t_q, t_d;
    logic [KLW-1:0]    keff_q, keff_d;
    logic [N*DW-1:0]   a_edge_q, a_edge_d;
    logic [N*DW-1:0]   b_edge_q, b_edge_d;
    logic              pe_en_q, pe_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Operand banks: no reset, contents survive both runs and reset.
    logic [DW-1:0]     a_mem [N][KMAX];
    logic [DW-1:0]     b_mem [KMAX][N];

    logic [KLW-1:0]    keff_in;
    logic [TW-1:0]     t_last;
    logic              feed;
    logic [TW-1:0]     feed_t;
    logic [KLW-1:0]    feed_keff;
    int                d;

    assign keff_in = (k_len_i > KLW'(KMAX)) ? KLW'(KMAX) : k_len_i;
    assign t_last  = TW'(keff_q) + TW'(2 * N - 3);

    always_ff @(posedge clk_i) begin
        if (wr_en_i && (state_q == StIdle)) begin
            if (wr_sel_i) begin
                b_mem[wr_k_i][wr_idx_i] <= wr_data_i;
            end else begin
                a_mem[wr_idx_i][wr_k_i] <= wr_data_i;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        keff_d    = keff_q;
        pe_en_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        a_edge_d  = '0;
        b_edge_d  = '0;
        feed      = 1'b0;
        feed_t    = '0;
        feed_keff = keff_q;
        d         = 0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    keff_d = keff_in;
                    t_d    = '0;
                    if (keff_in == '0) begin
                        // Empty run: a bare BUSY/DONE cycle, no feed.
                        state_d = StFin;
                        busy_d  = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = StFeed;
                        feed      = 1'b1;
                        feed_t    = '0;
                        feed_keff = keff_in;
                    end
                end
            end
            StFeed: begin
                if (t_q == t_last) begin
                    state_d = StFin;
                    t_d     = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    t_d    = t_q + 1'b1;
                    feed   = 1'b1;
                    feed_t = t_q + 1'b1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Edge data for the t that the registered outputs will show next cycle.
        if (feed) begin
            pe_en_d = 1'b1;
            busy_d  = 1'b1;
            for (int i = 0; i < int'(N); i++) begin
                d = int'(feed_t) - i;
                if (d >= 0 && d < int'(feed_keff)) begin
                    a_edge_d[i*DW +: DW] = a_mem[i][d[KW-1:0]];
                    b_edge_d[i*DW +: DW] = b_mem[d[KW-1:0]][i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            t_q      <= '0;
            keff_q   <= '0;
            a_edge_q <= '0;
            b_edge_q <= '0;
            pe_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            keff_q   <= keff_d;
            a_edge_q <= a_edge_d;
            b_edge_q <= b_edge_d;
            pe_en_q  <= pe_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign a_edge_o = a_edge_q;
    assign b_edge_o = b_edge_q;
    assign pe_en_o  = pe_en_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

`ifdef SYSTOLIC_FEEDER_CYCCNT_EN
    logic [15:0] cyc_cnt_q, cyc_cnt_d;

    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if ((state_q == StIdle) && start_i) begin
            cyc_cnt_d = '0;
        end else if (pe_en_q && (cyc_cnt_q != 16'hFFFF)) begin
            cyc_cnt_d = cyc_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign cyc_cnt_o = cyc_cnt_q;
`endif

endmodule
